// File: rtl/vga_obj_motion_ctrl.sv
// vga_obj_motion_ctrl
//   Per-frame motion controller for the single rectangle drawn by the 640x480
//   VGA pixel path. Move requests are latched as sticky flags during the frame
//   and applied in a single update at the start of vertical blanking. The new
//   position is clamped to the active area, then obj_x_o/obj_y_o are published.
//   Because the update only happens during blanking, the pixel path never
//   sees the position change during active video.
//
//   The position registers load on the CALC->COMMIT edge. The new position
//   therefore shows up in the same cycle as frame_tick_o, which is two cycles
//   after the blank_start cycle (hc==2 on the generator's count).
//
//   Optional build macro: VGA_OBJ_BOUNCE_EN
//     undefined : movement comes only from button requests.
//     defined   : a free-running bounce is added. Direction bits dir_x/dir_y
//                 add +/-STEP each frame and reflect when the clamp is reached.
//                 Buttons force the direction (up/left -> 0, down/right -> 1).
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   ACCUM  | active video; sticky request flags collect btn_* levels
//   CALC   | blank start seen; next position computed from flags
//   COMMIT | new position visible, frame_tick_o high, flags cleared

module vga_obj_motion_ctrl #(
  parameter int VFP    = 511,
  parameter int ACT_W  = 640,
  parameter int ACT_H  = 480,
  parameter int OBJ_W  = 100,
  parameter int OBJ_H  = 20,
  parameter int X_INIT = 240,
  parameter int Y_INIT = 100,
  parameter int STEP   = 4
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic [9:0] hc_i,
  input  logic [9:0] vc_i,
  input  logic       btn_up_i,
  input  logic       btn_dn_i,
  input  logic       btn_lt_i,
  input  logic       btn_rt_i,
  output logic [9:0] obj_x_o,
  output logic [9:0] obj_y_o,
  output logic       frame_tick_o,
  output logic [7:0] frame_cnt_o
);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] X_MAX  = 11'(ACT_W - OBJ_W);
  localparam logic signed [10:0] Y_MAX  = 11'(ACT_H - OBJ_H);

  state_t state_q, state_d;

  logic req_u_q, req_u_d;
  logic req_d_q, req_d_d;
  logic req_l_q, req_l_d;
  logic req_r_q, req_r_d;

  logic [9:0] obj_x_q, obj_x_d;
  logic [9:0] obj_y_q, obj_y_d;
  logic       tick_q, tick_d;
  logic [7:0] cnt_q, cnt_d;

  logic signed [10:0] dx, dy;
  logic signed [10:0] nx_raw, ny_raw;
  logic               blank_start;

`ifdef VGA_OBJ_BOUNCE_EN
  logic dir_x_q, dir_x_d;
  logic dir_y_q, dir_y_d;
  logic dir_x_eff, dir_y_eff;
`endif

  // One-axis button delta: opposing requests cancel.
  function automatic logic signed [10:0] axis_step(input logic neg, input logic pos);
    if (neg && !pos) return -STEP_S;
    if (pos && !neg) return STEP_S;
    return 11'sd0;
  endfunction

  // Limit a signed candidate position to [0, hi].
  function automatic logic [9:0] clamp_pos(input logic signed [10:0] v,
                                           input logic signed [10:0] hi);
    if (v < 11'sd0) return 10'd0;
    if (v > hi)     return 10'(hi);
    return 10'(v);
  endfunction

`ifdef VGA_OBJ_BOUNCE_EN
  // An axis counts as limited once the candidate reaches either edge. That
  // makes the reflection take effect on the frame that touches the wall.
  function automatic logic at_limit(input logic signed [10:0] v,
                                    input logic signed [10:0] hi);
    return (v <= 11'sd0) || (v >= hi);
  endfunction
`endif

  assign blank_start = (hc_i == 10'd0) && (vc_i == 10'(VFP));

  // State register; clr returns the controller to ACCUM at once.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // Next-state: blank_start is only acted on in ACCUM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (blank_start) state_d = CALC;
      CALC:    state_d = COMMIT;
      COMMIT:  state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Sticky request flags: set only in ACCUM, cleared in COMMIT. Buttons seen
  // in CALC/COMMIT are therefore dropped.
  always_comb begin
    req_u_d = req_u_q;
    req_d_d = req_d_q;
    req_l_d = req_l_q;
    req_r_d = req_r_q;
    if (state_q == ACCUM) begin
      req_u_d = req_u_q | btn_up_i;
      req_d_d = req_d_q | btn_dn_i;
      req_l_d = req_l_q | btn_lt_i;
      req_r_d = req_r_q | btn_rt_i;
    end else if (state_q == COMMIT) begin
      req_u_d = 1'b0;
      req_d_d = 1'b0;
      req_l_d = 1'b0;
      req_r_d = 1'b0;
    end
  end

  // Candidate position from the flags, kept in 11-bit signed form so that
  // moves past the left/top edge show up as negative values.
  always_comb begin
    dx = axis_step(req_l_q, req_r_q);
    dy = axis_step(req_u_q, req_d_q);
`ifdef VGA_OBJ_BOUNCE_EN
    dir_x_eff = dir_x_q;
    if (req_l_q && !req_r_q)      dir_x_eff = 1'b0;
    else if (req_r_q && !req_l_q) dir_x_eff = 1'b1;
    dir_y_eff = dir_y_q;
    if (req_u_q && !req_d_q)      dir_y_eff = 1'b0;
    else if (req_d_q && !req_u_q) dir_y_eff = 1'b1;
    dx = dx + (dir_x_eff ? STEP_S : -STEP_S);
    dy = dy + (dir_y_eff ? STEP_S : -STEP_S);
`endif
    nx_raw = $signed({1'b0, obj_x_q}) + dx;
    ny_raw = $signed({1'b0, obj_y_q}) + dy;
  end

  // Published values change only when CALC completes.
  always_comb begin
    obj_x_d = obj_x_q;
    obj_y_d = obj_y_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
`ifdef VGA_OBJ_BOUNCE_EN
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
`endif
    if (state_q == CALC) begin
      obj_x_d = clamp_pos(nx_raw, X_MAX);
      obj_y_d = clamp_pos(ny_raw, Y_MAX);
      cnt_d   = cnt_q + 8'd1;
      tick_d  = 1'b1;
`ifdef VGA_OBJ_BOUNCE_EN
      dir_x_d = at_limit(nx_raw, X_MAX) ? ~dir_x_eff : dir_x_eff;
      dir_y_d = at_limit(ny_raw, Y_MAX) ? ~dir_y_eff : dir_y_eff;
`endif
    end
  end

  // Flag, position, tick and frame-counter registers.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      req_u_q <= 1'b0;
      req_d_q <= 1'b0;
      req_l_q <= 1'b0;
      req_r_q <= 1'b0;
      obj_x_q <= 10'(X_INIT);
      obj_y_q <= 10'(Y_INIT);
      tick_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      req_u_q <= req_u_d;
      req_d_q <= req_d_d;
      req_l_q <= req_l_d;
      req_r_q <= req_r_d;
      obj_x_q <= obj_x_d;
      obj_y_q <= obj_y_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef VGA_OBJ_BOUNCE_EN
  // Bounce direction bits; both start moving in the + direction.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
    end else begin
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
    end
  end
`endif

  assign obj_x_o      = obj_x_q;
  assign obj_y_o      = obj_y_q;
  assign frame_tick_o = tick_q;
  assign frame_cnt_o  = cnt_q;

endmodule
